// File: rtl/attn_pkg.sv
// Shared definitions for the attention score datapath: score width, minimum score,
// buffer state encoding and a saturating signed subtract.
package attn_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // a - b computed one bit wider, then clamped back into DATA_WIDTH signed range.
    function automatic logic [DATA_WIDTH-1:0] sat_sub(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] diff;
        diff = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1])
            sat_sub = diff[DATA_WIDTH] ? SCORE_MIN : ~SCORE_MIN;
        else
            sat_sub = diff[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/score_sat_sub.sv
// Combinational signed saturating subtractor y = sat(a - b), shared with the softmax stage.
module score_sat_sub #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [DATA_WIDTH:0] diff;

    always_comb begin
        diff = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        // Top two bits disagree only when the true difference left the signed range.
        if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1])
            y = diff[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
        else
            y = diff[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/attn_score_buffer.sv
// Collects one attention row of Q.K scores, tracks its max/argmax, then streams
// the max-normalised scores (score - max) to the softmax stage.
module attn_score_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQLEN     = 64,
    parameter int ADDR_W     = $clog2(SEQLEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_score,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_score,
    output logic [ADDR_W-1:0]     out_index,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] row_max,
    output logic [ADDR_W-1:0]     row_argmax
);

    import attn_pkg::*;

    localparam logic [ADDR_W-1:0]     LAST_IDX  = ADDR_W'(SEQLEN - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                state;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [DATA_WIDTH-1:0] score_buf [SEQLEN];
    logic [DATA_WIDTH-1:0] rd_score;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            row_max    <= MIN_SCORE;
            row_argmax <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        // Strict compare keeps the earliest index on ties.
                        if ($signed(in_score) > $signed(row_max)) begin
                            row_max    <= in_score;
                            row_argmax <= wr_ptr;
                        end
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr    <= '0;
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (rd_ptr == LAST_IDX) begin
                            rd_ptr     <= '0;
                            row_max    <= MIN_SCORE;
                            row_argmax <= '0;
                            state      <= FILL;
                            in_ready   <= 1'b1;
                            out_valid  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    // Storage is deliberately unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!reset && in_ready && in_valid)
            score_buf[wr_ptr] <= in_score;
    end

    assign rd_score = score_buf[rd_ptr];

    score_sat_sub #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sat_sub (
        .a(rd_score),
        .b(row_max),
        .y(out_score)
    );

    assign out_index = rd_ptr;
    assign out_last  = out_valid && (rd_ptr == LAST_IDX);

endmodule

// File: tb/tb_attn_score_buffer.sv
// Self-checking bench for attn_score_buffer against a row-level reference model.
module tb_attn_score_buffer;

    localparam int DW = 16;
    localparam int N  = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_score;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_score;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic [DW-1:0] row_max;
    logic [AW-1:0] row_argmax;

    int tests = 0;
    int fails = 0;

    int row [N];
    int exp_max;
    int exp_arg;

    always #5 clk = ~clk;

    attn_score_buffer #(
        .DATA_WIDTH(DW),
        .SEQLEN(N),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_score(in_score),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_score(out_score),
        .out_index(out_index),
        .out_last(out_last),
        .row_max(row_max),
        .row_argmax(row_argmax)
    );

    task automatic model_row();
        exp_max = -32768;
        exp_arg = 0;
        for (int i = 0; i < N; i++) begin
            if (row[i] > exp_max) begin
                exp_max = row[i];
                exp_arg = i;
            end
        end
    endtask

    function automatic logic [DW-1:0] exp_out(input int i);
        int d;
        d = row[i] - exp_max;
        if (d < -32768) d = -32768;
        return DW'(d);
    endfunction

    function automatic int rand_score();
        logic signed [DW-1:0] t;
        t = DW'($urandom);
        return int'(t);
    endfunction

    // Feeds row[0..n-1] back-to-back; leaves in_valid high after the last beat.
    task automatic send_row(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                tests++;
                if ({row_max, row_argmax} !== {16'h8000, 6'd0}) begin
                    fails++;
                    $display("FAIL %s row_start_max: got max=%h arg=%0d want max=8000 arg=0", name, row_max, row_argmax);
                end
            end
            tests++;
            if ({in_ready, out_valid} !== 2'b10) begin
                fails++;
                $display("FAIL %s fill_flags beat %0d: got in_ready=%b out_valid=%b want 1/0", name, i, in_ready, out_valid);
            end
            in_valid  = 1'b1;
            in_score  = DW'(row[i]);
            out_ready = 1'b0;
        end
    endtask

    // mode 0: ready always, 1: pattern 1,0,0,1, 2: random. stop_at>=0 asserts reset at that index.
    task automatic drain_row(input string name, input int mode, input int stop_at, input bit pulses);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        model_row();
        while (idx < N && cyc < 400) begin
            @(negedge clk);
            cyc++;
            tests++;
            if ({out_valid, in_ready} !== 2'b10) begin
                fails++;
                $display("FAIL %s drain_flags idx %0d: got out_valid=%b in_ready=%b want 1/0", name, idx, out_valid, in_ready);
            end
            tests++;
            if (out_index !== AW'(idx)) begin
                fails++;
                $display("FAIL %s out_index: got %0d want %0d", name, out_index, idx);
            end
            tests++;
            if (out_score !== exp_out(idx)) begin
                fails++;
                $display("FAIL %s out_score idx %0d: got %h want %h", name, idx, out_score, exp_out(idx));
            end
            tests++;
            if (out_last !== (idx == N - 1)) begin
                fails++;
                $display("FAIL %s out_last idx %0d: got %b want %b", name, idx, out_last, idx == N - 1);
            end
            tests++;
            if ({row_max, row_argmax} !== {DW'(exp_max), AW'(exp_arg)}) begin
                fails++;
                $display("FAIL %s row_max/argmax: got %h/%0d want %h/%0d", name, row_max, row_argmax, DW'(exp_max), exp_arg);
            end
            if (idx == stop_at) begin
                reset     = 1'b1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                return;
            end
            in_valid = pulses ? 1'($urandom) : 1'b0;
            in_score = DW'($urandom);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                default: rdy = 1'($urandom);
            endcase
            out_ready = rdy;
            if (rdy) idx++;
        end
        tests++;
        if (idx < N) begin
            fails++;
            $display("FAIL %s drain_timeout: got %0d handshakes want %0d", name, idx, N);
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++;
        if ({out_valid, in_ready, row_max, row_argmax} !== {1'b0, 1'b1, 16'h8000, 6'd0}) begin
            fails++;
            $display("FAIL %s idle: got out_valid=%b in_ready=%b max=%h arg=%0d want 0/1/8000/0",
                     name, out_valid, in_ready, row_max, row_argmax);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_score  = 16'h7FFF;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({out_valid, in_ready, out_last, row_max, row_argmax} !== {1'b0, 1'b1, 1'b0, 16'h8000, 6'd0}) begin
            fails++;
            $display("FAIL reset_state: got out_valid=%b in_ready=%b last=%b max=%h arg=%0d",
                     out_valid, in_ready, out_last, row_max, row_argmax);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) row[i] = i;
        send_row("ramp", N);
        drain_row("ramp", 0, -1, 1'b0);
        idle_check("ramp");
    endtask

    task automatic test_ties();
        for (int i = 0; i < N; i++) row[i] = 'h0100;
        row[5] = 'h0200;
        row[9] = 'h0200;
        send_row("ties", N);
        drain_row("ties", 0, -1, 1'b0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < N; i++) row[i] = -32768;
        row[0] = 32767;
        send_row("saturate", N);
        drain_row("saturate", 0, -1, 1'b0);
        for (int i = 0; i < N; i++) row[i] = -32768;
        send_row("all_min", N);
        drain_row("all_min", 2, -1, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < N; i++) row[i] = rand_score();
        send_row("stall", N);
        drain_row("stall", 1, -1, 1'b1);
        idle_check("stall");
    endtask

    task automatic test_reset_fill();
        for (int i = 0; i < N; i++) row[i] = rand_score();
        send_row("reset_fill_partial", 30);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_score = 16'h7FFF;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) row[i] = 100 + i;
        send_row("reset_fill", N);
        drain_row("reset_fill", 0, -1, 1'b0);
    endtask

    task automatic test_reset_drain();
        for (int i = 0; i < N; i++) row[i] = rand_score();
        send_row("reset_drain", N);
        drain_row("reset_drain", 0, 10, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({out_valid, in_ready, row_max, row_argmax} !== {1'b0, 1'b1, 16'h8000, 6'd0}) begin
            fails++;
            $display("FAIL reset_drain_after: got out_valid=%b in_ready=%b max=%h arg=%0d want 0/1/8000/0",
                     out_valid, in_ready, row_max, row_argmax);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) row[i] = rand_score();
        row[7] = 'h7000;
        send_row("b2b_a", N);
        drain_row("b2b_a", 2, -1, 1'b0);
        for (int i = 0; i < N; i++) row[i] = int'($urandom_range(2000)) - 1000;
        send_row("b2b_b", N);
        drain_row("b2b_b", 0, -1, 1'b0);
        idle_check("b2b_b");
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_score  = '0;
        out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_ties();
        test_saturate();
        test_stall();
        test_reset_fill();
        test_reset_drain();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
